// File: rtl/rx_frame_pkg.sv
// Frame layout and receiver state encoding shared by the frame receive path.
package rx_frame_pkg;

  localparam int FRAME_W         = 11;
  localparam int START_B         = 10;
  localparam int DATA_HI         = 9;
  localparam int DATA_LO         = 2;
  localparam int PAR_B           = 1;
  localparam int STOP_B          = 0;
  localparam int DATA_W          = DATA_HI - DATA_LO + 1;
  localparam int TICKS_PER_FRAME = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT,
    ST_CHECK,
    ST_FLUSH
  } rx_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small synchronous byte FIFO; head is shown combinationally and reads as zero when empty.
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_rx_controller.sv
// Sequences the 11-bit deserializer: frame timing, word check, error counting and byte queueing.
module frame_rx_controller
  import rx_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 Clock,
  input  logic                 iReset,
  input  logic                 i1b,
  input  logic                 iBitTick,
  input  logic [FRAME_W-1:0]   iFrame,
  output logic                 oDesReset,
  output logic [DATA_W-1:0]    oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [ERR_CNT_W-1:0] oParityErrs,
  output logic [ERR_CNT_W-1:0] oFrameErrs,
  output logic                 oOverflow
);

  localparam int TO_W   = $clog2(TIMEOUT) + 1;
  localparam int TICK_W = $clog2(TICKS_PER_FRAME + 1);

  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic                 flush_q, flush_d;
  logic                 des_rst_q, des_rst_d;
  logic [ERR_CNT_W-1:0] par_errs_q, par_errs_d;
  logic [ERR_CNT_W-1:0] frm_errs_q, frm_errs_d;
  logic                 ovf_q, ovf_d;

  logic [DATA_W-1:0]    frame_byte;
  logic                 start_ok, stop_ok, par_ok, frame_ok;
  logic                 push, pop, fifo_full, fifo_empty;

  // The first data bit on the wire sits just below the start bit and is the byte LSB.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_byte
    assign frame_byte[gi] = iFrame[DATA_HI - gi];
  end

  assign start_ok = ~iFrame[START_B];
  assign stop_ok  = iFrame[STOP_B];
  assign par_ok   = ^iFrame[DATA_HI:PAR_B];
  assign frame_ok = start_ok & stop_ok & par_ok;
  assign push     = (state_q == ST_CHECK) & frame_ok;
  assign pop      = oValid & iReady;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    to_d       = to_q;
    flush_d    = flush_q;
    des_rst_d  = des_rst_q;
    par_errs_d = par_errs_q;
    frm_errs_d = frm_errs_q;
    ovf_d      = ovf_q | (push & fifo_full & ~pop);
    case (state_q)
      ST_IDLE: begin
        if (iBitTick && !i1b) begin
          state_d = ST_RECV;
          tick_d  = TICK_W'(1);
          to_d    = '0;
        end
      end
      ST_RECV, ST_WAIT: begin
        if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = ST_FLUSH;
          flush_d   = 1'b0;
          des_rst_d = 1'b1;
          if (~&frm_errs_q) frm_errs_d = frm_errs_q + 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (state_q == ST_WAIT) begin
            state_d = ST_CHECK;
          end else if (iBitTick) begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_W'(TICKS_PER_FRAME - 1)) state_d = ST_WAIT;
          end
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_FLUSH;
          flush_d   = 1'b0;
          des_rst_d = 1'b1;
          // Framing faults take precedence so each bad frame bumps exactly one counter.
          if (!start_ok || !stop_ok) begin
            if (~&frm_errs_q) frm_errs_d = frm_errs_q + 1'b1;
          end else if (~&par_errs_q) begin
            par_errs_d = par_errs_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q) begin
          state_d   = ST_IDLE;
          des_rst_d = 1'b0;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_FLUSH;
        flush_d   = 1'b0;
        des_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (iReset) begin
      state_q    <= ST_FLUSH;
      tick_q     <= '0;
      to_q       <= '0;
      flush_q    <= 1'b0;
      des_rst_q  <= 1'b1;
      par_errs_q <= '0;
      frm_errs_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      to_q       <= to_d;
      flush_q    <= flush_d;
      des_rst_q  <= des_rst_d;
      par_errs_q <= par_errs_d;
      frm_errs_q <= frm_errs_d;
      ovf_q      <= ovf_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (Clock),
    .srst_i  (iReset),
    .push_i  (push),
    .data_i  (frame_byte),
    .pop_i   (pop),
    .data_o  (oData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign oValid      = ~fifo_empty;
  assign oDesReset   = des_rst_q;
  assign oParityErrs = par_errs_q;
  assign oFrameErrs  = frm_errs_q;
  assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_frame_rx_controller.sv
// Scenario bench for frame_rx_controller; accepted bytes are tracked in a scoreboard queue.
module tb_frame_rx_controller;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 200;
  localparam int ERR_CNT_W  = 8;
  localparam int TICK_GAP   = 3;

  logic                 Clock = 1'b0;
  logic                 iReset;
  logic                 i1b;
  logic                 iBitTick;
  logic [10:0]          iFrame;
  logic                 oDesReset;
  logic [7:0]           oData;
  logic                 oValid;
  logic                 iReady;
  logic [ERR_CNT_W-1:0] oParityErrs;
  logic [ERR_CNT_W-1:0] oFrameErrs;
  logic                 oOverflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  frame_rx_controller #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .Clock       (Clock),
    .iReset      (iReset),
    .i1b         (i1b),
    .iBitTick    (iBitTick),
    .iFrame      (iFrame),
    .oDesReset   (oDesReset),
    .oData       (oData),
    .oValid      (oValid),
    .iReady      (iReady),
    .oParityErrs (oParityErrs),
    .oFrameErrs  (oFrameErrs),
    .oOverflow   (oOverflow)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every handshake must deliver the oldest byte still expected.
  always @(negedge Clock) begin
    if (!iReset && oValid && iReady) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got byte %02h, no byte expected", oData);
      end else begin
        logic [7:0] want;
        want = exp_q.pop_front();
        if (oData !== want) begin
          n_bad++;
          $display("FAIL sb_data: got %02h expected %02h", oData, want);
        end else begin
          $display("pop byte %02h", oData);
        end
      end
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_start,
                                             input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[10] = bad_start;
    for (int i = 0; i < 8; i++) f[9-i] = d[i];
    f[1] = ~(^d) ^ bad_par;
    f[0] = ~bad_stop;
    return f;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Returns #1 after the 12th tick edge (controller is then in WAIT).
  task automatic drive_frame(input logic [10:0] f);
    iFrame = f;
    for (int t = 0; t < 12; t++) begin
      i1b      = (t == 0) ? 1'b0 : 1'b1;
      iBitTick = 1'b1;
      cyc(1);
      iBitTick = 1'b0;
      i1b      = 1'b1;
      if (t < 11) cyc(TICK_GAP - 1);
    end
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    cyc(3);
    iReset = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    $display("test_reset");
    iReset = 1'b1;
    cyc(3);
    n_cmp++; if (oDesReset !== 1'b1) begin n_bad++; $display("FAIL rst_desreset: got %b expected 1", oDesReset); end
    n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", oValid); end
    n_cmp++; if (oData !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %02h expected 00", oData); end
    n_cmp++; if (oParityErrs !== 8'd0) begin n_bad++; $display("FAIL rst_parerrs: got %0d expected 0", oParityErrs); end
    n_cmp++; if (oFrameErrs !== 8'd0) begin n_bad++; $display("FAIL rst_frmerrs: got %0d expected 0", oFrameErrs); end
    n_cmp++; if (oOverflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b expected 0", oOverflow); end
    iReset = 1'b0;
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b1) begin n_bad++; $display("FAIL rst_flush1: got %b expected 1", oDesReset); end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b0) begin n_bad++; $display("FAIL rst_flush_end: got %b expected 0", oDesReset); end
  endtask

  task automatic test_good_frame();
    $display("test_good_frame");
    do_reset();
    iReady = 1'b0;
    drive_frame(make_frame(8'h5A, 0, 0, 0));
    cyc(1);
    n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL gf_valid_early: got %b expected 0", oValid); end
    exp_q.push_back(8'h5A);
    cyc(1);
    n_cmp++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL gf_valid: got %b expected 1", oValid); end
    n_cmp++; if (oData !== 8'h5A) begin n_bad++; $display("FAIL gf_data: got %02h expected 5a", oData); end
    n_cmp++; if (oParityErrs !== 8'd0 || oFrameErrs !== 8'd0) begin
      n_bad++; $display("FAIL gf_counters: got par=%0d frm=%0d expected 0/0", oParityErrs, oFrameErrs);
    end
    n_cmp++; if (oDesReset !== 1'b0) begin n_bad++; $display("FAIL gf_desreset: got %b expected 0", oDesReset); end
    iReady = 1'b1;
    cyc(2);
    n_cmp++; if (oValid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL gf_drain: got valid=%b pending=%0d expected 0/0", oValid, exp_q.size());
    end
  endtask

  task automatic test_parity_error();
    $display("test_parity_error");
    do_reset();
    iReady = 1'b1;
    drive_frame(make_frame(8'h5A, 0, 1, 0));
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b0) begin n_bad++; $display("FAIL pe_desreset_check: got %b expected 0", oDesReset); end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b1) begin n_bad++; $display("FAIL pe_flush1: got %b expected 1", oDesReset); end
    n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL pe_valid: got %b expected 0", oValid); end
    n_cmp++; if (oParityErrs !== 8'd1) begin n_bad++; $display("FAIL pe_parerrs: got %0d expected 1", oParityErrs); end
    n_cmp++; if (oFrameErrs !== 8'd0) begin n_bad++; $display("FAIL pe_frmerrs: got %0d expected 0", oFrameErrs); end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b1) begin n_bad++; $display("FAIL pe_flush2: got %b expected 1", oDesReset); end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b0) begin n_bad++; $display("FAIL pe_flush_end: got %b expected 0", oDesReset); end
    exp_q.push_back(8'hC3);
    drive_frame(make_frame(8'hC3, 0, 0, 0));
    cyc(5);
    n_cmp++; if (exp_q.size() != 0 || oValid !== 1'b0) begin
      n_bad++; $display("FAIL pe_recover: got pending=%0d valid=%b expected 0/0", exp_q.size(), oValid);
    end
    n_cmp++; if (oParityErrs !== 8'd1) begin n_bad++; $display("FAIL pe_parerrs_after: got %0d expected 1", oParityErrs); end
  endtask

  task automatic test_frame_errors();
    $display("test_frame_errors");
    do_reset();
    iReady = 1'b1;
    drive_frame(make_frame(8'h5A, 0, 1, 1));
    cyc(5);
    n_cmp++; if (oFrameErrs !== 8'd1) begin n_bad++; $display("FAIL fe_stop_frm: got %0d expected 1", oFrameErrs); end
    n_cmp++; if (oParityErrs !== 8'd0) begin n_bad++; $display("FAIL fe_stop_par: got %0d expected 0", oParityErrs); end
    drive_frame(make_frame(8'hA5, 1, 0, 0));
    cyc(5);
    n_cmp++; if (oFrameErrs !== 8'd2) begin n_bad++; $display("FAIL fe_start_frm: got %0d expected 2", oFrameErrs); end
    drive_frame(make_frame(8'h0F, 1, 0, 1));
    cyc(5);
    n_cmp++; if (oFrameErrs !== 8'd3 || oParityErrs !== 8'd0) begin
      n_bad++; $display("FAIL fe_both: got frm=%0d par=%0d expected 3/0", oFrameErrs, oParityErrs);
    end
    n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL fe_valid: got %b expected 0", oValid); end
  endtask

  task automatic test_timeout();
    int n;
    $display("test_timeout");
    do_reset();
    iReady = 1'b1;
    iFrame = make_frame(8'h3C, 0, 0, 0);
    n = 0;
    i1b = 1'b0; iBitTick = 1'b1;
    cyc(1);
    i1b = 1'b1; iBitTick = 1'b0;
    for (int t = 1; t < 5; t++) begin
      for (int g = 0; g < TICK_GAP - 1; g++) begin cyc(1); n++; end
      iBitTick = 1'b1;
      cyc(1); n++;
      iBitTick = 1'b0;
    end
    while (!oDesReset && n < TIMEOUT + 20) begin
      cyc(1); n++;
    end
    n_cmp++; if (oDesReset !== 1'b1 || n < TIMEOUT - 1 || n > TIMEOUT + 1) begin
      n_bad++; $display("FAIL to_latency: got %0d cycles (desreset=%b) expected %0d", n, oDesReset, TIMEOUT);
    end
    n_cmp++; if (oFrameErrs !== 8'd1 || oParityErrs !== 8'd0) begin
      n_bad++; $display("FAIL to_counters: got frm=%0d par=%0d expected 1/0", oFrameErrs, oParityErrs);
    end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b1) begin n_bad++; $display("FAIL to_flush2: got %b expected 1", oDesReset); end
    cyc(1);
    n_cmp++; if (oDesReset !== 1'b0) begin n_bad++; $display("FAIL to_idle: got %b expected 0", oDesReset); end
    exp_q.push_back(8'h3C);
    drive_frame(make_frame(8'h3C, 0, 0, 0));
    cyc(5);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL to_recover: got pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5];
    bit         exp_ovf;
    int         n;
    $display("test_overflow");
    do_reset();
    iReady  = 1'b0;
    bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(bytes[i]);
      else exp_ovf = 1'b1;
      drive_frame(make_frame(bytes[i], 0, 0, 0));
      cyc(5);
      n_cmp++; if (oOverflow !== exp_ovf) begin
        n_bad++; $display("FAIL ov_flag_%0d: got %b expected %b", i, oOverflow, exp_ovf);
      end
    end
    n_cmp++; if (oValid !== 1'b1 || oData !== exp_q[0]) begin
      n_bad++; $display("FAIL ov_head: got valid=%b data=%02h expected 1/%02h", oValid, oData, exp_q[0]);
    end
    iReady = 1'b1;
    n = 0;
    while (oValid && n < 20) begin cyc(1); n++; end
    n_cmp++; if (oValid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL ov_drain: got valid=%b pending=%0d expected 0/0", oValid, exp_q.size());
    end
    n_cmp++; if (oOverflow !== 1'b1) begin n_bad++; $display("FAIL ov_sticky: got %b expected 1", oOverflow); end
  endtask

  task automatic test_full_with_pop();
    int n;
    $display("test_full_with_pop");
    do_reset();
    iReady = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      logic [7:0] b;
      b = 8'hA1 + 8'(i);
      exp_q.push_back(b);
      drive_frame(make_frame(b, 0, 0, 0));
      cyc(5);
    end
    exp_q.push_back(8'hB7);
    drive_frame(make_frame(8'hB7, 0, 0, 0));
    cyc(1);
    iReady = 1'b1;
    cyc(1);
    iReady = 1'b0;
    cyc(2);
    n_cmp++; if (oOverflow !== 1'b0) begin n_bad++; $display("FAIL fp_overflow: got %b expected 0", oOverflow); end
    n_cmp++; if (oData !== exp_q[0]) begin n_bad++; $display("FAIL fp_head: got %02h expected %02h", oData, exp_q[0]); end
    iReady = 1'b1;
    n = 0;
    while (oValid && n < 20) begin cyc(1); n++; end
    n_cmp++; if (oValid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL fp_drain: got valid=%b pending=%0d expected 0/0", oValid, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    $display("test_saturation");
    do_reset();
    iReady = 1'b1;
    for (int i = 0; i < 255; i++) begin
      drive_frame(make_frame(8'(i), 0, 1, 0));
      cyc(5);
    end
    n_cmp++; if (oParityErrs !== 8'hFF) begin n_bad++; $display("FAIL sat_reach: got %0d expected 255", oParityErrs); end
    drive_frame(make_frame(8'h77, 0, 1, 0));
    cyc(5);
    n_cmp++; if (oParityErrs !== 8'hFF) begin n_bad++; $display("FAIL sat_hold: got %0d expected 255", oParityErrs); end
    n_cmp++; if (oFrameErrs !== 8'd0 || oValid !== 1'b0) begin
      n_bad++; $display("FAIL sat_side: got frm=%0d valid=%b expected 0/0", oFrameErrs, oValid);
    end
  endtask

  initial begin
    iReset   = 1'b1;
    i1b      = 1'b1;
    iBitTick = 1'b0;
    iFrame   = '0;
    iReady   = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_errors();
    test_timeout();
    test_overflow();
    test_full_with_pop();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
